// File: rtl/complement_to_signmag.sv
`default_nettype none
// ============================================================================
// Module  : complement_to_signmag
// Brief   : Bit-serial (LSB first) ones'/two's complement to sign-magnitude
//           converter with start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
module complement_to_signmag #(
   parameter int WIDTH    = 4,
   parameter bit ONES_CPL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] val,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] mag,
   output logic             sign
);

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_op;
   logic [WIDTH-1:0] r_res;
   logic [IW-1:0]    r_idx;
   logic             r_neg;
   logic             r_carry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_res   <= '0;
         r_idx   <= '0;
         r_neg   <= 1'b0;
         r_carry <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mag     <= '0;
         sign    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op    <= val;
                  r_neg   <= val[WIDTH-1];
                  r_idx   <= '0;
                  r_carry <= ~ONES_CPL;
                  busy    <= 1'b1;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               // Negation ripples the +1 (two's) carry LSB first; ones' starts with carry 0.
               if (r_neg) begin
                  r_res[r_idx] <= ~r_op[r_idx] ^ r_carry;
                  r_carry      <= ~r_op[r_idx] & r_carry;
               end else begin
                  r_res[r_idx] <= r_op[r_idx];
               end
               if (r_idx == IW'(WIDTH-1)) begin
                  r_state <= S_DONE;
               end
               r_idx <= r_idx + IW'(1);
            end
            S_DONE: begin
               // Negative zero (ones' all-ones) normalises to +0.
               mag     <= r_res;
               sign    <= r_neg & (|r_res);
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_complement_to_signmag.sv
`default_nettype none
// Bench for complement_to_signmag: ones' and two's complement instances share
// stimulus and are checked every cycle against an arithmetic reference model.
module tb_complement_to_signmag;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] val = '0;

   logic         busy1, done1, sign1;
   logic [W-1:0] mag1;
   logic         busy0, done0, sign0;
   logic [W-1:0] mag0;

   complement_to_signmag #(.WIDTH(W), .ONES_CPL(1'b1)) u_ones (
      .clk(clk), .rst(rst), .start(start), .val(val),
      .busy(busy1), .done(done1), .mag(mag1), .sign(sign1)
   );

   complement_to_signmag #(.WIDTH(W), .ONES_CPL(1'b0)) u_twos (
      .clk(clk), .rst(rst), .start(start), .val(val),
      .busy(busy0), .done(done0), .mag(mag0), .sign(sign0)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Signed value of a W-bit pattern, then its absolute value and sign.
   function automatic int val_ones(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - ((1 << W) - 1) : int'(v);
   endfunction
   function automatic int val_twos(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
   endfunction
   function automatic int absval(input int s);
      return (s < 0) ? -s : s;
   endfunction

   // Reference model: a conversion occupies W+1 edges after acceptance.
   int           m_cnt = 0;
   logic [W-1:0] m_val = '0;
   logic [W-1:0] e_mag1 = '0, e_mag0 = '0;
   logic         e_sign1 = 1'b0, e_sign0 = 1'b0, e_done = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt = 0; e_done = 1'b0;
         e_mag1 = '0; e_sign1 = 1'b0; e_mag0 = '0; e_sign0 = 1'b0;
      end else begin
         e_done = 1'b0;
         if (m_cnt == W + 1) begin
            e_done  = 1'b1;
            e_mag1  = W'(absval(val_ones(m_val)));
            e_sign1 = val_ones(m_val) < 0;
            e_mag0  = W'(absval(val_twos(m_val)));
            e_sign0 = val_twos(m_val) < 0;
            m_cnt   = 0;
         end else if (m_cnt != 0) begin
            m_cnt++;
         end else if (start) begin
            m_val = val;
            m_cnt = 1;
         end
      end
   end

   logic [6:0] cmp_exp1, cmp_exp0;
   always @(negedge clk) begin
      cmp_exp1 = {m_cnt != 0, e_done, e_mag1, e_sign1};
      cmp_exp0 = {m_cnt != 0, e_done, e_mag0, e_sign0};
      chk("cycle_ones", {busy1, done1, mag1, sign1}, cmp_exp1);
      chk("cycle_twos", {busy0, done0, mag0, sign0}, cmp_exp0);
   end

   // Launch one conversion; lat = edges from acceptance until done seen.
   task automatic convert(input logic [W-1:0] v, output int lat);
      @(negedge clk);
      val = v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic conv_chk(input string name, input logic [W-1:0] v,
                           input logic [W-1:0] m1, input logic s1,
                           input logic [W-1:0] m0, input logic s0);
      int lat;
      convert(v, lat);
      chk({name, "_lat"},   lat, W + 1);
      chk({name, "_mag1"},  mag1, m1);
      chk({name, "_sign1"}, sign1, s1);
      chk({name, "_mag0"},  mag0, m0);
      chk({name, "_sign0"}, sign0, s0);
   endtask

   int n_done, gap;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_outs1", {busy1, done1, mag1, sign1}, 0);
      chk("rst_outs0", {busy0, done0, mag0, sign0}, 0);
      rst = 1'b1;

      // Basic ones'/two's conversions with literal expectations
      conv_chk("pos0101", 4'b0101, 4'b0101, 1'b0, 4'b0101, 1'b0);
      conv_chk("neg1010", 4'b1010, 4'b0101, 1'b1, 4'b0110, 1'b1);
      conv_chk("neg1111", 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1);
      conv_chk("neg1101", 4'b1101, 4'b0010, 1'b1, 4'b0011, 1'b1);
      conv_chk("neg1000", 4'b1000, 4'b0111, 1'b1, 4'b1000, 1'b1);
      conv_chk("zero",    4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // Handshake: starts during CONV and DONE are ignored
      @(negedge clk);
      val = 4'b0110; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done1) n_done++;
         if (k == 1) begin val = 4'b1001; start = 1'b1; end
         if (k == 2) begin start = 1'b0; chk("hold_mag", mag1, 4'b0000); end
         if (k == 4) begin val = 4'b1111; start = 1'b1; end
         if (k == 5) begin
            start = 1'b0;
            chk("hs_done_at5", done1, 1'b1);
            chk("hs_mag1", mag1, 4'b0110);
         end
      end
      chk("hs_one_done", n_done, 1);
      chk("hs_sign1", sign1, 1'b0);

      // Asynchronous reset mid-conversion
      @(negedge clk);
      val = 4'b1011; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_outs1", {busy1, done1, mag1, sign1}, 0);
      chk("arst_outs0", {busy0, done0, mag0, sign0}, 0);
      @(negedge clk);
      rst = 1'b1;
      conv_chk("after_rst", 4'b1001, 4'b0110, 1'b1, 4'b0111, 1'b1);

      // Continuous start with alternating operand
      @(negedge clk);
      val = 4'b0011; start = 1'b1;
      for (int d = 0; d < 4; d++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (!done1 && gap < 20);
         if (d > 0) chk("bb_period", gap, W + 2);
         chk("bb_mag1",  mag1,  4'b0011);
         chk("bb_sign1", sign1, d % 2);
         chk("bb_mag0",  mag0,  (d % 2) ? 4'b0100 : 4'b0011);
         val = (d % 2) ? 4'b0011 : 4'b1100;
      end
      start = 1'b0;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
